// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor, diff = a - b - bin.
// One full-subtractor cell is reused once per clock, LSB first, with the
// borrow carried between bits in a flip-flop. Results are published only
// on completion, so diff never exposes a partially built word.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Holds the WIDTH-1 bits produced so far; the final bit joins on the
  // completing edge straight from the cell.
  logic [WIDTH-2:0] res_sr;
  logic             br;
  logic [CW-1:0]    count;

  logic             d;
  logic             br_next;
  logic [WIDTH-1:0] res_next;

  // Full-subtractor cell on the current LSBs plus the result word it completes.
  always_comb begin
    d        = a_sr[0] ^ b_sr[0] ^ br;
    br_next  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    res_next = {d, res_sr};
  end

  // Control FSM, operand/result shifting and registered outputs.
  // NOTE: every register here uses <= so all updates see pre-edge values;
  // a blocking assignment would let later lines read already-shifted data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      br         <= 1'b0;
      count      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      zero       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // DONE lasts one cycle; both states accept a new request.
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            br    <= bin;
            count <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // start is deliberately ignored here; operands stay untouched.
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          br     <= br_next;
          res_sr <= res_next[WIDTH-1:1];
          count  <= count + CW'(1);
          if (count == LAST_BIT) begin
            diff       <= res_next;
            borrow_out <= br_next;
            zero       <= (res_next == '0);
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
